selector_addr_sequencer: RTL
============================

# selector_addr_sequencer

Upstream driver for the 16-bit one-hot selector (`Selector_16`).
- Accepts address requests over a valid/ready handshake, covering either a single address or a burst of consecutive addresses.
- Drives the selector's address bus and holds it stable for a programmable settle time, since the 65536-wide decode tree is slow.
- Reports each settled address downstream with a second valid/ready handshake.
- Downstream logic samples `decoded` only while `sel_stable` is high.

## Interface
Parameters:
- `ADDR_W`, 16, address width; must match the selector input width.
- `SETTLE_CYCLES`, 4, cycles `sel_addr` is held before the decode is declared stable; legal range 1..255.
- `CNT_W`, 8, settle counter width.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `req_valid`  in  1  request offered.
- `req_ready`  out  1  block can accept a request.
- `req_addr`  in  ADDR_W  first address of the burst.
- `req_cnt`  in  ADDR_W  burst length minus 1; 0 means a single address.
- `abort`  in  1  synchronous cancel of the current burst.
- `sel_addr`  out  ADDR_W  registered address driven into `Selector_16`.
- `sel_stable`  out  1  `decoded` output is settled for `sel_addr`.
- `rsp_valid`  out  1  settled address reported.
- `rsp_ready`  in  1  consumer accepts the report.
- `rsp_addr`  out  ADDR_W  reported address; always equals `sel_addr`.
- `rsp_last`  out  1  reported address is the final one of the burst.
- `busy`  out  1  state is not IDLE.

## Operation
- FSM states are IDLE, SETTLE and REPORT.
- IDLE:
  - `req_ready`=1.
  - On `req_valid` && `req_ready`: `sel_addr`<=`req_addr`, `remain`<=`req_cnt`, `settle`<=`SETTLE_CYCLES`-1, then go to SETTLE.
- SETTLE:
  - `settle` decrements each cycle.
  - When `settle`==0, go to REPORT.
- REPORT:
  - `rsp_valid`=`sel_stable`=1.
  - `rsp_last`=(`remain`==0).
  - On `rsp_ready`, if `remain`==0: go to IDLE. `sel_addr` holds its last value.
  - On `rsp_ready`, otherwise: `sel_addr`<=`sel_addr`+1 modulo 2^ADDR_W, so 0xFFFF wraps to 0x0000. `remain`<=`remain`-1, `settle` reloads, and the FSM goes to SETTLE.
  - Without `rsp_ready`, all outputs hold (standard valid/ready; `rsp_valid` never drops without a handshake except on `abort` or reset).
- `abort`:
  - From any state, go to IDLE on the next edge and deassert `rsp_valid` and `sel_stable`.
  - `abort` has priority over a simultaneous `rsp_ready` or `req_valid`; a request offered in the same cycle is not accepted.
- `req_cnt`=0xFFFF sweeps all 65536 addresses and ends on `req_addr`-1 (mod 2^16).
- `req_ready` is the combinational decode state==IDLE. It has no path from `req_valid`.

## Timing
- Reset values: `sel_addr`=0, `sel_stable`=0, `rsp_valid`=0, `rsp_last`=0, `busy`=0, `req_ready`=1. `remain`=0 and `settle`=0 internally.
- Request accepted at edge N:
  - `sel_addr` is new after edge N.
  - `rsp_valid` is first high in the cycle after edge N+`SETTLE_CYCLES`.
- `sel_addr` is stable for at least `SETTLE_CYCLES` full cycles before `sel_stable` rises.
- With `rsp_ready` held at 1, addresses advance one every `SETTLE_CYCLES`+1 cycles.
- Burst end: the last handshake returns the FSM to IDLE. A new request can be accepted on the following edge, so there is one idle cycle minimum between bursts.
- Reset asserted mid-burst clears all state immediately (asynchronously). No response is emitted after reset release.

## Structure
- Package `selector_pkg` holds:
  - the state enum (IDLE/SETTLE/REPORT);
  - `ADDR_W` default and address typedef;
  - the `SETTLE_CYCLES` default.
- Sub-module `selector_settle_timer`:
  - loadable down-counter;
  - inputs `load` and `load_val`;
  - output `done`=(count==0);
  - asynchronous active-low reset.
- The top instantiates the timer plus the FSM and address/remain registers.
- The bench instantiates the top with `Selector_16` on `sel_addr`.

## Test plan
- Reset, then single request with `req_addr`=0x0001 and `req_cnt`=0 (`SETTLE_CYCLES`=4):
  - `rsp_valid` is high 4 cycles after acceptance with `rsp_addr`=0x0001 and `rsp_last`=1.
  - While `sel_stable`=1: `decoded[1]`=1, `decoded[0]`=0, `decoded[2]`=0.
- Burst `req_addr`=0xFFFE, `req_cnt`=3, `rsp_ready` tied 1:
  - Reports 0xFFFE, 0xFFFF, 0x0000, 0x0001, spaced 5 cycles apart.
  - `rsp_last` is high only on 0x0001.
- Backpressure: `rsp_ready`=0 for 10 cycles during REPORT:
  - `rsp_valid`, `rsp_addr` and `sel_addr` hold.
  - The next address appears only after `rsp_ready`=1.
- `abort` pulsed during SETTLE of the 2nd address in a burst of 5:
  - IDLE on the next edge, `rsp_valid`=0, `req_ready`=1.
  - A simultaneous `req_valid` is ignored.
- `rst_n` asserted mid-burst:
  - Outputs go immediately to reset values (`sel_addr`=0, `busy`=0).
  - No stale report after release.
- 10 random single requests:
  - Each `rsp_addr` matches its request.
  - `decoded` is one-hot at `rsp_addr` while `sel_stable`=1.

Source files
------------

// File: rtl/selector_addr_sequencer_pkg.sv
// Shared types and defaults for the selector address sequencer.
package selector_pkg;

  localparam int unsigned ADDR_W_DEF        = 16;
  localparam int unsigned SETTLE_CYCLES_DEF = 4;

  typedef logic [ADDR_W_DEF-1:0] addr_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    REPORT = 2'd2
  } state_e;

endpackage

// File: rtl/Selector_16.sv
// 16-bit to 65536-line one-hot decoder driven by the sequencer.
module Selector_16 (
  input  logic [15:0]    sel,
  output logic [65535:0] decoded
);

  always_comb begin
    decoded      = '0;
    decoded[sel] = 1'b1;
  end

endmodule

// File: rtl/selector_addr_sequencer_settle_timer.sv
// Loadable down-counter timing how long sel_addr has been held.
module selector_settle_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (count_q != '0) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign done = (count_q == '0);

endmodule

// File: rtl/selector_addr_sequencer.sv
// Drives Selector_16 addresses, waits for decode settle, reports each address.
module selector_addr_sequencer
  import selector_pkg::*;
#(
  parameter int unsigned ADDR_W        = ADDR_W_DEF,
  parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEF,
  parameter int unsigned CNT_W         = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [ADDR_W-1:0] req_cnt,
  input  logic              abort,
  output logic [ADDR_W-1:0] sel_addr,
  output logic              sel_stable,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic              rsp_last,
  output logic              busy
);

  state_e            state_q;
  logic [ADDR_W-1:0] sel_addr_q;
  logic [ADDR_W-1:0] remain_q;
  logic              rsp_valid_q;
  logic              rsp_last_q;
  logic              timer_load;
  logic              timer_done;

  // Timer reloads on acceptance and on every non-final handshake; abort blocks both.
  assign timer_load = !abort &&
                      (((state_q == IDLE) && req_valid) ||
                       ((state_q == REPORT) && rsp_ready && (remain_q != '0)));

  selector_settle_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .load_val (CNT_W'(SETTLE_CYCLES - 1)),
    .done     (timer_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sel_addr_q  <= '0;
      remain_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_last_q  <= 1'b0;
    end else if (abort) begin
      state_q     <= IDLE;
      rsp_valid_q <= 1'b0;
      rsp_last_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            sel_addr_q <= req_addr;
            remain_q   <= req_cnt;
            state_q    <= SETTLE;
          end
        end
        SETTLE: begin
          if (timer_done) begin
            state_q     <= REPORT;
            rsp_valid_q <= 1'b1;
            rsp_last_q  <= (remain_q == '0);
          end
        end
        REPORT: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            rsp_last_q  <= 1'b0;
            if (remain_q == '0) begin
              state_q <= IDLE;
            end else begin
              sel_addr_q <= sel_addr_q + 1'b1;
              remain_q   <= remain_q - 1'b1;
              state_q    <= SETTLE;
            end
          end
        end
        default: begin
          state_q     <= IDLE;
          rsp_valid_q <= 1'b0;
          rsp_last_q  <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign sel_addr   = sel_addr_q;
  assign rsp_addr   = sel_addr_q;
  assign rsp_valid  = rsp_valid_q;
  assign sel_stable = rsp_valid_q;
  assign rsp_last   = rsp_last_q;

endmodule
